blinky_led: RTL and testbench



---
 rtl/blinky_pkg.sv | 11 +
 rtl/blinky_tick.sv | 37 +++
 rtl/blinky_led.sv | 42 ++++
 tb/tb_blinky_led.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// Shared constants and types for the LED blink generator.
package blinky_pkg;

    localparam int BLINKY_CNT_WIDTH_DEFAULT   = 24;
    localparam int BLINKY_HALF_PERIOD_DEFAULT = 10;
    // 0.25 s half-period at a 50 MHz board clock.
    localparam int BLINKY_HALF_PERIOD_FPGA    = 12_500_000;

    typedef logic [BLINKY_CNT_WIDTH_DEFAULT-1:0] blinky_cnt_t;

endpackage

// File: rtl/blinky_tick.sv
// Modulo-N prescaler: emits a one-cycle tick on the enabled cycle that wraps the count.
module blinky_tick
    import blinky_pkg::*;
#(
    parameter int N         = BLINKY_HALF_PERIOD_DEFAULT,
    parameter int CNT_WIDTH = BLINKY_CNT_WIDTH_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 at_last;

    always_comb begin
        at_last  = (cnt_q == LAST);
        cnt_next = cnt_q;
        if (en_i) begin
            cnt_next = at_last ? '0 : cnt_q + CNT_WIDTH'(1);
        end
        tick_o = en_i & at_last;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/blinky_led.sv
// LED blink generator: registered output inverts every HALF_PERIOD enabled cycles.
module blinky_led
    import blinky_pkg::*;
#(
    parameter int HALF_PERIOD = BLINKY_HALF_PERIOD_DEFAULT,
    parameter int CNT_WIDTH   = BLINKY_CNT_WIDTH_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic blinky_o
);

    // The counter must be able to hold HALF_PERIOD-1 and the period must be nonzero.
    if (HALF_PERIOD < 1 || longint'(HALF_PERIOD) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_param
        $error("blinky_led: HALF_PERIOD out of range for CNT_WIDTH");
    end

    logic tick;
    logic led_q;

    blinky_tick #(
        .N         (HALF_PERIOD),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q <= 1'b0;
        end else if (tick) begin
            led_q <= ~led_q;
        end
    end

    assign blinky_o = led_q;

endmodule

// File: tb/tb_blinky_led.sv
// Self-checking bench for blinky_led: directed scenarios plus random enable/reset traffic.
module tb_blinky_led;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic blinky_a;
    logic blinky_b;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;   // enabled cycles since the last reset

    always #5 clk = ~clk;

    blinky_led #(.HALF_PERIOD(10), .CNT_WIDTH(24)) dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .blinky_o (blinky_a)
    );

    blinky_led #(.HALF_PERIOD(1), .CNT_WIDTH(4)) dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .blinky_o (blinky_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: update the reference at the rising edge, compare on the falling edge.
    // Reference: output = parity of (enabled cycles since reset / HALF_PERIOD).
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) en_cnt = 0;
        else if (en) en_cnt++;
        @(negedge clk);
        check("model_hp10", int'(blinky_a), (en_cnt / 10) % 2);
        check("model_hp1", int'(blinky_b), en_cnt % 2);
    endtask

    task automatic do_reset(input int n);
        rst_n  = 1'b0;
        en     = 1'b0;
        en_cnt = 0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int edges;
        int run_len;
        logic prev;

        rst_n = 1'b0;
        en    = 1'b0;

        // 1: reset then run
        do_reset(3);
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (i == 9)  check("s1_low9", int'(blinky_a), 0);
            if (i == 10) check("s1_rise10", int'(blinky_a), 1);
            if (i == 20) check("s1_fall20", int'(blinky_a), 0);
            if (i == 30) check("s1_rise30", int'(blinky_a), 1);
        end
        $display("scenario 1 reset-then-run done: checks=%0d errors=%0d", checks, errors);

        // 2: toggle count and run lengths
        do_reset(2);
        en      = 1'b1;
        prev    = blinky_a;
        edges   = 0;
        run_len = 1;
        for (int i = 1; i <= 210; i++) begin
            cycle();
            if (blinky_a !== prev) begin
                edges++;
                check("s2_run_len", run_len, 10);
                run_len = 1;
            end else begin
                run_len++;
            end
            prev = blinky_a;
        end
        check("s2_edges", edges, 21);
        $display("scenario 2 toggle-count done: edges=%0d errors=%0d", edges, errors);

        // 3: enable freeze
        do_reset(2);
        en = 1'b1;
        repeat (4) cycle();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("s3_frozen", int'(blinky_a), 0);
        end
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (i == 5) check("s3_before_rise", int'(blinky_a), 0);
            if (i == 6) check("s3_rise17", int'(blinky_a), 1);
        end
        $display("scenario 3 enable-freeze done: errors=%0d", errors);

        // 4: enable dropped on the terminal cycle
        do_reset(2);
        en = 1'b1;
        repeat (9) cycle();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s4_deferred", int'(blinky_a), 0);
        end
        en = 1'b1;
        cycle();
        check("s4_toggle", int'(blinky_a), 1);
        $display("scenario 4 terminal-disable done: errors=%0d", errors);

        // 5: asynchronous reset mid-period (output high, count at 6)
        do_reset(2);
        en = 1'b1;
        repeat (16) cycle();
        check("s5_pre_high", int'(blinky_a), 1);
        #2;
        rst_n  = 1'b0;
        en_cnt = 0;
        #1;
        check("s5_async_clear", int'(blinky_a), 0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 9)  check("s5_low9", int'(blinky_a), 0);
            if (i == 10) check("s5_rise10", int'(blinky_a), 1);
        end
        $display("scenario 5 async-reset done: errors=%0d", errors);

        // 6: HALF_PERIOD = 1
        do_reset(2);
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("s6_alternate", int'(blinky_b), i % 2);
        end
        $display("scenario 6 min-period done: errors=%0d", errors);

        // Random enable with occasional synchronous-edge reset pulses
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        $display("random phase done: errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
